psum_collector: RTL and testbench
=================================

# psum_collector

Consumes the time-aligned partial-sum stream produced by the psum delay chain, accumulates PASS_NB passes of one output row, and emits saturated output pixels through a small FIFO with valid/ready backpressure. It sits between the convolution array's psum delay output and the output writer. Its input has no backpressure: the input side is fire-and-forget, and any overflow is flagged.

## Interface
- SUM_BW, 16, signed width of incoming psum
- OUT_BW, 8, signed width of output pixel
- ROW_LEN, 27, psums per row pass
- PASS_NB, 3, passes accumulated per row (>=1)
- FIFO_DEPTH, 4, output FIFO entries (power of 2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle pulse that begins a row
- i_valid  in  1  i_psum qualifier
- i_psum  in  SUM_BW  signed partial sum
- o_valid  out  1  output pixel available
- o_data  out  OUT_BW  signed output pixel
- i_ready  in  1  downstream accepts o_data
- o_busy  out  1  high in ACCUM or DRAIN
- o_done  out  1  one-cycle pulse at row completion
- o_overflow  out  1  sticky; FIFO push dropped

## Operation
- Accumulator width: ACC_BW = SUM_BW + clog2(PASS_NB); add is sign-extended with no wrap.
- Storage: acc[0..ROW_LEN-1], plus counters idx (0..ROW_LEN-1) and pass (0..PASS_NB-1).
- FSM IDLE -> ACCUM on i_start; idx and pass are cleared.
- In IDLE, i_valid is ignored. In ACCUM/DRAIN, i_start is ignored.
- ACCUM, each i_valid:
  - pass 0: acc[idx] = i_psum
  - 0 < pass < PASS_NB-1: acc[idx] += i_psum
  - last pass: sum = acc[idx] + i_psum; push sat(sum) to FIFO
  - PASS_NB=1 means pass 0 is the last pass.
- idx wraps at ROW_LEN-1; pass increments on each wrap.
- The wrap at the last pass moves ACCUM -> DRAIN.
- DRAIN -> IDLE when the FIFO is empty. o_done pulses in that same transition cycle.
- sat(): clamp to [-2^(OUT_BW-1), 2^(OUT_BW-1)-1].
- FIFO push when full and not popping in the same cycle: the value is dropped, o_overflow sets, and the counters still advance. o_overflow clears only on reset.
- Push and pop in the same cycle while full: both occur, no overflow.
- Pop occurs on o_valid && i_ready.

## Timing
- Reset values: o_valid=0, o_data=0, o_busy=0, o_done=0, o_overflow=0. FSM=IDLE, FIFO empty, counters 0. acc contents are don't-care because pass 0 overwrites them.
- o_busy is registered and rises the cycle after i_start.
- i_valid is accepted starting the cycle after i_start.
- Latency: an i_valid at the last pass, sampled at edge t, gives o_valid=1 after edge t, when the FIFO was empty.
- o_data is registered, first-word fall-through, and stable while o_valid && !i_ready.
- Reset asserted mid-row aborts the row immediately. No o_done is issued, and the FIFO is flushed.
- Back-to-back rows: i_start is accepted the cycle after o_done (FSM in IDLE).

## Configuration
- PSUM_RELU_EN defined: sat() first clamps negative sums to 0, so the output range is [0, 2^(OUT_BW-1)-1].
- PSUM_RELU_EN undefined: signed saturation only.

## Structure
- The shared package/include holds:
  - FSM state encodings ST_IDLE/ST_ACCUM/ST_DRAIN
  - the clog2 function
  - the ACC_BW derivation
- Sub-module psum_fifo:
  - parameterised synchronous FIFO (width OUT_BW, depth FIFO_DEPTH)
  - ports push/pop/full/empty, first-word fall-through output
- psum_collector holds the FSM, counters, accumulator array and saturation logic.

## Test plan
Bench overrides: ROW_LEN=4, PASS_NB=3, OUT_BW=8, SUM_BW=16.
- Basic row: start, then 12 psums of value 10, i_ready=1 → 4 outputs of 30, then o_done one cycle after the FIFO empties.
- Saturation: last-pass sums of +200 and -300 → o_data 127 and -128. With PSUM_RELU_EN, -300 → 0.
- Backpressure/overflow: i_ready=0 for the whole row with FIFO_DEPTH=4 → FIFO full, no overflow; then i_ready=1 → 4 pixels in order. Repeat with ROW_LEN=5 → o_overflow=1 and 4 pixels out.
- Full-FIFO simultaneous push/pop: FIFO full and i_ready=1 on the push cycle → no overflow, ordering preserved.
- Reset mid-row: rst_n low during pass 1 → all outputs 0. A following clean row gives the correct 30s, with no stale data.
- Ignored inputs: i_valid in IDLE and a second i_start during ACCUM → no effect on outputs or counts.

Source files
------------

// File: rtl/psum_collector_pkg.sv
// Shared definitions for the partial-sum collector: FSM encoding and width helpers.
package psum_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Accumulator grows by one bit per doubling of the pass count so the row sum never wraps.
  function automatic int acc_bw(input int sum_bw, input int pass_nb);
    return sum_bw + clog2(pass_nb);
  endfunction

  // Counter width that stays legal for a count of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// First-word fall-through FIFO for output pixels. DEPTH must be a power of two, >= 2.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module psum_fifo
  import psum_collector_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int PTR_W = cnt_w(DEPTH);
  localparam int CNT_W = clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_q];

  // Next-state for storage, pointers and occupancy; a simultaneous pop frees the slot being written.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (do_pop) rd_d = rd_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset flushes contents so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Accumulates PASS_NB passes of a ROW_LEN psum row and emits saturated pixels via psum_fifo.
// Optional feature: define PSUM_RELU_EN to clamp negative row sums to zero before saturation.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int SUM_BW     = 16,
  parameter int OUT_BW     = 8,
  parameter int ROW_LEN    = 27,
  parameter int PASS_NB    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [SUM_BW-1:0] i_psum,
  output logic              o_valid,
  output logic [OUT_BW-1:0] o_data,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow
);
  localparam int ACC_BW = acc_bw(SUM_BW, PASS_NB);
  localparam int IDX_W  = cnt_w(ROW_LEN);
  localparam int PASS_W = cnt_w(PASS_NB);
  localparam logic [IDX_W-1:0]         IDX_LAST  = IDX_W'(ROW_LEN - 1);
  localparam logic [PASS_W-1:0]        PASS_LAST = PASS_W'(PASS_NB - 1);
  localparam logic signed [ACC_BW-1:0] SAT_MAX   = ACC_BW'((1 << (OUT_BW - 1)) - 1);
  localparam logic signed [ACC_BW-1:0] SAT_MIN   = ~SAT_MAX;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [PASS_W-1:0]         pass_q, pass_d;
  logic                      busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic signed [ACC_BW-1:0]  acc_q [ROW_LEN];
  logic signed [ACC_BW-1:0]  acc_d [ROW_LEN];
  logic signed [ACC_BW-1:0]  psum_ext, sum;
  logic [OUT_BW-1:0]         sat_val;
  logic                      last_pass, push, pop, fifo_full, fifo_empty;

  assign o_valid    = !fifo_empty;
  assign pop        = !fifo_empty && i_ready;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overflow = ovf_q;

  // Running sum for the current column and its clamp to the output range.
  always_comb begin
    psum_ext = ACC_BW'($signed(i_psum));
    sum      = (pass_q == '0) ? psum_ext : acc_q[idx_q] + psum_ext;
    if (sum > SAT_MAX)      sat_val = SAT_MAX[OUT_BW-1:0];
    else if (sum < SAT_MIN) sat_val = SAT_MIN[OUT_BW-1:0];
    else                    sat_val = sum[OUT_BW-1:0];
`ifdef PSUM_RELU_EN
    if (sum[ACC_BW-1]) sat_val = '0;
`endif
  end

  // Row sequencing: counters, accumulator update, FIFO push and status flags.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    last_pass = (pass_q == PASS_LAST);
    push      = 1'b0;
    case (state_q)
      ST_IDLE: if (i_start) begin
        state_d = ST_ACCUM;
        idx_d   = '0;
        pass_d  = '0;
      end
      ST_ACCUM: if (i_valid) begin
        if (last_pass) push = 1'b1;
        else           acc_d[idx_q] = sum;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          if (last_pass) begin
            pass_d  = '0;
            state_d = ST_DRAIN;
          end else begin
            pass_d = pass_q + PASS_W'(1);
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: if (fifo_empty) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    ovf_d  = ovf_q || (push && fifo_full && !pop);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pass_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Accumulator storage needs no reset: pass 0 overwrites every entry.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  psum_fifo #(.WIDTH(OUT_BW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (sat_val),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (o_data)
  );

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: a 4-wide row instance plus a 5-wide one for FIFO overflow cases.
module tb_psum_collector;
  localparam int ROW_LEN = 4, PASS_NB = 3, OUT_BW = 8, SUM_BW = 16, DEPTH = 4;
  localparam int NV = ROW_LEN * PASS_NB;
  localparam int NV5 = 5 * PASS_NB;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic i_start = 0, i_valid = 0, i_ready = 1;
  logic [SUM_BW-1:0] i_psum = '0;
  logic o_valid, o_busy, o_done, o_overflow;
  logic [OUT_BW-1:0] o_data;

  logic i_start_5 = 0, i_valid_5 = 0, i_ready_5 = 1;
  logic [SUM_BW-1:0] i_psum_5 = '0;
  logic o_valid_5, o_busy_5, o_done_5, o_overflow_5;
  logic [OUT_BW-1:0] o_data_5;

  psum_collector #(.SUM_BW(SUM_BW), .OUT_BW(OUT_BW), .ROW_LEN(ROW_LEN), .PASS_NB(PASS_NB),
                   .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_valid(i_valid), .i_psum(i_psum),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready), .o_busy(o_busy),
    .o_done(o_done), .o_overflow(o_overflow));

  psum_collector #(.SUM_BW(SUM_BW), .OUT_BW(OUT_BW), .ROW_LEN(5), .PASS_NB(PASS_NB),
                   .FIFO_DEPTH(DEPTH)) dut5 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start_5), .i_valid(i_valid_5), .i_psum(i_psum_5),
    .o_valid(o_valid_5), .o_data(o_data_5), .i_ready(i_ready_5), .o_busy(o_busy_5),
    .o_done(o_done_5), .o_overflow(o_overflow_5));

  int vec = 0, err = 0, cyc = 0;
  int got_q[$], got5_q[$];
  int last_pop_cyc = 0, done_cyc = 0, done_cnt = 0;
  int vals [15];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted pixel and every done pulse.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      got_q.push_back(int'($signed(o_data)));
      last_pop_cyc = cyc;
    end
    if (rst_n && o_valid_5 && i_ready_5) got5_q.push_back(int'($signed(o_data_5)));
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference: clamp a full row sum to the output pixel range.
  function automatic int sat_ref(input int s);
`ifdef PSUM_RELU_EN
    if (s < 0) return 0;
`endif
    if (s > 127) return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  // Reference: pixel k of a row of length rl is the saturated sum of its column over all passes.
  function automatic int exp_pix(input int k, input int rl);
    int s = 0;
    for (int p = 0; p < PASS_NB; p++) s += vals[p * rl + k];
    return sat_ref(s);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vals(input int n);
    for (int i = 0; i < n; i++) vals[i] = int'($urandom_range(0, 200)) - 100;
  endtask

  task automatic send_row(input bit gaps, input bit rnd_rdy, input int restart_at);
    i_start = 1;
    tick();
    i_start = 0;
    for (int i = 0; i < NV; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_valid = 0;
        if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
        tick();
      end
      i_valid = 1;
      i_psum  = 16'(vals[i]);
      i_start = (i == restart_at);
      if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
      tick();
    end
    i_valid = 0;
    i_start = 0;
  endtask

  task automatic send_row5(input bit rdy_last);
    i_start_5 = 1;
    tick();
    i_start_5 = 0;
    i_ready_5 = 0;
    for (int i = 0; i < NV5; i++) begin
      i_valid_5 = 1;
      i_psum_5  = 16'(vals[i]);
      if (i == NV5 - 1) i_ready_5 = rdy_last;
      tick();
    end
    i_valid_5 = 0;
  endtask

  task automatic wait_done(input bit rnd_rdy, output bit ok);
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
      tick();
      if (o_done) ok = 1;
    end
    i_ready = 1;
    tick();
  endtask

  task automatic wait_done5(output bit ok);
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      tick();
      if (o_done_5) ok = 1;
    end
    tick();
  endtask

  task automatic test_reset;
    #12;
    vec += 6;
    if (o_valid !== 1'b0)   begin err++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    if (o_data !== '0)      begin err++; $display("FAIL rst_data got %0h exp 0", o_data); end
    if (o_busy !== 1'b0)    begin err++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    if (o_done !== 1'b0)    begin err++; $display("FAIL rst_done got %b exp 0", o_done); end
    if (o_overflow !== 1'b0) begin err++; $display("FAIL rst_ovf got %b exp 0", o_overflow); end
    if (o_valid_5 !== 1'b0) begin err++; $display("FAIL rst_valid5 got %b exp 0", o_valid_5); end
    @(posedge clk);
    #1 rst_n = 1;
    tick();
  endtask

  task automatic test_basic;
    bit ok;
    int d0 = done_cnt;
    got_q.delete();
    i_ready = 1;
    i_start = 1;
    tick();
    i_start = 0;
    vec++;
    if (o_busy !== 1'b1) begin err++; $display("FAIL basic_busy got %b exp 1", o_busy); end
    for (int i = 0; i < NV; i++) begin
      if (i == 2 * ROW_LEN) begin
        vec++;
        if (o_valid !== 1'b0) begin err++; $display("FAIL basic_pre_valid got %b exp 0", o_valid); end
      end
      i_valid = 1;
      i_psum  = 16'd10;
      tick();
      if (i == 2 * ROW_LEN) begin
        vec += 2;
        if (o_valid !== 1'b1) begin err++; $display("FAIL basic_latency got %b exp 1", o_valid); end
        if (int'($signed(o_data)) != 30)
          begin err++; $display("FAIL basic_first got %0d exp 30", $signed(o_data)); end
      end
    end
    i_valid = 0;
    wait_done(0, ok);
    vec += 5;
    if (!ok) begin err++; $display("FAIL basic_done_timeout got 0 exp 1"); end
    if (got_q.size() != ROW_LEN) begin err++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), ROW_LEN); end
    if (done_cyc - last_pop_cyc != 2)
      begin err++; $display("FAIL basic_done_timing got %0d exp 2", done_cyc - last_pop_cyc); end
    if (done_cnt - d0 != 1) begin err++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt - d0); end
    if (o_busy !== 1'b0) begin err++; $display("FAIL basic_idle_busy got %b exp 0", o_busy); end
    foreach (got_q[k]) begin
      vec++;
      if (got_q[k] != 30) begin err++; $display("FAIL basic_pix%0d got %0d exp 30", k, got_q[k]); end
    end
  endtask

  task automatic test_saturation;
    bit ok;
    vals[0:11] = '{100, -100, 100, -100, 50, -100, 20, -20, 50, -100, 7, -8};
    got_q.delete();
    i_ready = 1;
    send_row(0, 0, -1);
    wait_done(0, ok);
    vec += 2;
    if (!ok) begin err++; $display("FAIL sat_done_timeout got 0 exp 1"); end
    if (got_q.size() != ROW_LEN) begin err++; $display("FAIL sat_count got %0d exp %0d", got_q.size(), ROW_LEN); end
    foreach (got_q[k]) begin
      vec++;
      if (got_q[k] != exp_pix(k, ROW_LEN))
        begin err++; $display("FAIL sat_pix%0d got %0d exp %0d", k, got_q[k], exp_pix(k, ROW_LEN)); end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [OUT_BW-1:0] held;
    int d0 = done_cnt;
    rand_vals(NV);
    got_q.delete();
    i_ready = 0;
    send_row(1, 0, -1);
    i_ready = 0;
    held = o_data;
    repeat (3) tick();
    vec += 5;
    if (o_valid !== 1'b1)    begin err++; $display("FAIL bp_valid got %b exp 1", o_valid); end
    if (o_overflow !== 1'b0) begin err++; $display("FAIL bp_ovf got %b exp 0", o_overflow); end
    if (o_busy !== 1'b1)     begin err++; $display("FAIL bp_busy got %b exp 1", o_busy); end
    if (done_cnt != d0)      begin err++; $display("FAIL bp_early_done got %0d exp %0d", done_cnt, d0); end
    if (o_data !== held)     begin err++; $display("FAIL bp_stable got %0h exp %0h", o_data, held); end
    i_ready = 1;
    wait_done(0, ok);
    vec += 2;
    if (!ok) begin err++; $display("FAIL bp_done_timeout got 0 exp 1"); end
    if (got_q.size() != ROW_LEN) begin err++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), ROW_LEN); end
    foreach (got_q[k]) begin
      vec++;
      if (got_q[k] != exp_pix(k, ROW_LEN))
        begin err++; $display("FAIL bp_pix%0d got %0d exp %0d", k, got_q[k], exp_pix(k, ROW_LEN)); end
    end
  endtask

  task automatic test_full_pushpop;
    bit ok;
    rand_vals(NV5);
    got5_q.delete();
    send_row5(1);
    i_ready_5 = 1;
    wait_done5(ok);
    vec += 3;
    if (!ok) begin err++; $display("FAIL fpp_done_timeout got 0 exp 1"); end
    if (o_overflow_5 !== 1'b0) begin err++; $display("FAIL fpp_ovf got %b exp 0", o_overflow_5); end
    if (got5_q.size() != 5) begin err++; $display("FAIL fpp_count got %0d exp 5", got5_q.size()); end
    foreach (got5_q[k]) begin
      vec++;
      if (got5_q[k] != exp_pix(k, 5))
        begin err++; $display("FAIL fpp_pix%0d got %0d exp %0d", k, got5_q[k], exp_pix(k, 5)); end
    end
  endtask

  task automatic test_overflow;
    bit ok;
    rand_vals(NV5);
    got5_q.delete();
    send_row5(0);
    i_ready_5 = 0;
    repeat (2) tick();
    vec += 2;
    if (o_overflow_5 !== 1'b1) begin err++; $display("FAIL ovf_flag got %b exp 1", o_overflow_5); end
    if (o_busy_5 !== 1'b1)     begin err++; $display("FAIL ovf_busy got %b exp 1", o_busy_5); end
    i_ready_5 = 1;
    wait_done5(ok);
    vec += 3;
    if (!ok) begin err++; $display("FAIL ovf_done_timeout got 0 exp 1"); end
    if (got5_q.size() != DEPTH) begin err++; $display("FAIL ovf_count got %0d exp %0d", got5_q.size(), DEPTH); end
    if (o_overflow_5 !== 1'b1) begin err++; $display("FAIL ovf_sticky got %b exp 1", o_overflow_5); end
    foreach (got5_q[k]) begin
      vec++;
      if (got5_q[k] != exp_pix(k, 5))
        begin err++; $display("FAIL ovf_pix%0d got %0d exp %0d", k, got5_q[k], exp_pix(k, 5)); end
    end
  endtask

  task automatic test_reset_midrow;
    bit ok;
    int d0;
    for (int i = 0; i < NV; i++) vals[i] = 10 + i;
    i_ready = 0;
    i_start = 1;
    tick();
    i_start = 0;
    for (int i = 0; i < ROW_LEN + 2; i++) begin
      i_valid = 1;
      i_psum  = 16'(vals[i]);
      tick();
    end
    i_valid = 0;
    rst_n = 0;
    #2;
    vec += 5;
    if (o_valid !== 1'b0)      begin err++; $display("FAIL mid_valid got %b exp 0", o_valid); end
    if (o_data !== '0)         begin err++; $display("FAIL mid_data got %0h exp 0", o_data); end
    if (o_busy !== 1'b0)       begin err++; $display("FAIL mid_busy got %b exp 0", o_busy); end
    if (o_done !== 1'b0)       begin err++; $display("FAIL mid_done got %b exp 0", o_done); end
    if (o_overflow_5 !== 1'b0) begin err++; $display("FAIL mid_ovf got %b exp 0", o_overflow_5); end
    repeat (2) tick();
    rst_n = 1;
    tick();
    for (int i = 0; i < NV; i++) vals[i] = 10;
    got_q.delete();
    d0 = done_cnt;
    i_ready = 1;
    send_row(0, 0, -1);
    wait_done(0, ok);
    vec += 3;
    if (!ok) begin err++; $display("FAIL mid_done_timeout got 0 exp 1"); end
    if (got_q.size() != ROW_LEN) begin err++; $display("FAIL mid_count got %0d exp %0d", got_q.size(), ROW_LEN); end
    if (done_cnt - d0 != 1) begin err++; $display("FAIL mid_done_pulses got %0d exp 1", done_cnt - d0); end
    foreach (got_q[k]) begin
      vec++;
      if (got_q[k] != 30) begin err++; $display("FAIL mid_pix%0d got %0d exp 30", k, got_q[k]); end
    end
  endtask

  task automatic test_ignored;
    bit ok;
    int d0 = done_cnt;
    got_q.delete();
    i_ready = 1;
    for (int c = 0; c < 3; c++) begin
      i_valid = 1;
      i_psum  = 16'd99;
      tick();
    end
    i_valid = 0;
    vec += 2;
    if (o_busy !== 1'b0)  begin err++; $display("FAIL ign_idle_busy got %b exp 0", o_busy); end
    if (o_valid !== 1'b0) begin err++; $display("FAIL ign_idle_valid got %b exp 0", o_valid); end
    rand_vals(NV);
    send_row(0, 0, 5);
    wait_done(0, ok);
    vec += 3;
    if (!ok) begin err++; $display("FAIL ign_done_timeout got 0 exp 1"); end
    if (got_q.size() != ROW_LEN) begin err++; $display("FAIL ign_count got %0d exp %0d", got_q.size(), ROW_LEN); end
    if (done_cnt - d0 != 1) begin err++; $display("FAIL ign_done_pulses got %0d exp 1", done_cnt - d0); end
    foreach (got_q[k]) begin
      vec++;
      if (got_q[k] != exp_pix(k, ROW_LEN))
        begin err++; $display("FAIL ign_pix%0d got %0d exp %0d", k, got_q[k], exp_pix(k, ROW_LEN)); end
    end
  endtask

  task automatic test_random_rows;
    bit ok;
    for (int r = 0; r < 6; r++) begin
      rand_vals(NV);
      got_q.delete();
      send_row(1, 1, -1);
      wait_done(1, ok);
      vec += 2;
      if (!ok) begin err++; $display("FAIL rnd%0d_done_timeout got 0 exp 1", r); end
      if (got_q.size() != ROW_LEN)
        begin err++; $display("FAIL rnd%0d_count got %0d exp %0d", r, got_q.size(), ROW_LEN); end
      foreach (got_q[k]) begin
        vec++;
        if (got_q[k] != exp_pix(k, ROW_LEN))
          begin err++; $display("FAIL rnd%0d_pix%0d got %0d exp %0d", r, k, got_q[k], exp_pix(k, ROW_LEN)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_full_pushpop();
    test_overflow();
    test_reset_midrow();
    test_ignored();
    test_random_rows();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
